// File: rtl/branch_predict_unit_pkg.sv
// Shared defines for the branch predictor: branch ALU op codes, branch-kind enum,
// decode helper and saturating-counter reset value.
package branch_predict_unit_pkg;

  localparam logic [7:0] EXE_BEQ_OP    = 8'b0101_0001;
  localparam logic [7:0] EXE_BNE_OP    = 8'b0101_0010;
  localparam logic [7:0] EXE_BLEZ_OP   = 8'b0101_0011;
  localparam logic [7:0] EXE_BGTZ_OP   = 8'b0101_0100;
  localparam logic [7:0] EXE_BGEZ_OP   = 8'b0100_0001;
  localparam logic [7:0] EXE_BGEZAL_OP = 8'b0100_1011;
  localparam logic [7:0] EXE_BLTZ_OP   = 8'b0100_0000;
  localparam logic [7:0] EXE_BLTZAL_OP = 8'b0100_1010;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_GTZ  = 3'd3,
    BR_LEZ  = 3'd4,
    BR_GEZ  = 3'd5,
    BR_LTZ  = 3'd6
  } br_kind_e;

  function automatic br_kind_e br_decode(input logic [7:0] aluop);
    br_kind_e kind;
    case (aluop)
      EXE_BEQ_OP:                   kind = BR_EQ;
      EXE_BNE_OP:                   kind = BR_NE;
      EXE_BGTZ_OP:                  kind = BR_GTZ;
      EXE_BLEZ_OP:                  kind = BR_LEZ;
      EXE_BGEZ_OP, EXE_BGEZAL_OP:   kind = BR_GEZ;
      EXE_BLTZ_OP, EXE_BLTZAL_OP:   kind = BR_LTZ;
      default:                      kind = BR_NONE;
    endcase
    return kind;
  endfunction

  // Weakly not-taken: the value just below the counter's MSB threshold.
  function automatic int unsigned bht_cnt_init(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_cond.sv
// branch_cond_eval: combinational branch condition evaluation from ALU op and operands.
module branch_cond_eval
  import branch_predict_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [7:0]        aluop,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  output logic              taken,
  output logic              is_branch
);

  br_kind_e kind_s;
  logic     sign_s;
  logic     zero_s;

  // Decode the op and resolve the condition on the operands.
  always_comb begin
    kind_s    = br_decode(aluop);
    sign_s    = reg1[DATA_W-1];
    zero_s    = (reg1 == {DATA_W{1'b0}});
    is_branch = (kind_s != BR_NONE);
    case (kind_s)
      BR_EQ:   taken = (reg1 == reg2);
      BR_NE:   taken = (reg1 != reg2);
      BR_GTZ:  taken = ~sign_s & ~zero_s;
      BR_LEZ:  taken = sign_s | zero_s;
      BR_GEZ:  taken = ~sign_s;
      BR_LTZ:  taken = sign_s;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with in-ID resolution and mispredict redirect.
// Optional macro BRANCH_PERF_EN adds resolution/mispredict performance counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int BHT_DEPTH = 256,
  parameter int CNT_W     = 2,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  input  logic [DATA_W-1:0] if_pc_i,
  output logic              pred_valid_o,
  output logic              pred_taken_o,
  input  logic              id_valid_i,
  input  logic [7:0]        aluop_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [DATA_W-1:0] id_pc_i,
  input  logic [DATA_W-1:0] id_target_i,
  input  logic              id_pred_taken_i,
  input  logic              flush_i,
  output logic              do_branch_o,
  output logic              mispredict_o,
  output logic [DATA_W-1:0] redirect_pc_o
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]       perf_branch_o,
  output logic [31:0]       perf_miss_o
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(bht_cnt_init(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN  = {CNT_W{1'b0}};
  localparam logic [DATA_W-1:0] DELAY_SLOT_SKIP = {{(DATA_W-4){1'b0}}, 4'd8};

  logic [CNT_W-1:0]  bht_r [BHT_DEPTH];
  logic [IDX_W-1:0]  lookup_idx_s;
  logic [IDX_W-1:0]  update_idx_s;
  logic [CNT_W-1:0]  cnt_cur_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              taken_s;
  logic              is_branch_s;
  logic              resolve_s;
  logic              miss_s;
  logic              pred_valid_r;
  logic              pred_taken_r;
  logic              mispredict_r;
  logic [DATA_W-1:0] redirect_pc_r;
  logic              unused_pc_bits_s;

  assign lookup_idx_s     = if_pc_i[IDX_W+1:2];
  assign update_idx_s     = id_pc_i[IDX_W+1:2];
  assign unused_pc_bits_s = ^{if_pc_i[DATA_W-1:IDX_W+2], if_pc_i[1:0]};

  branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
    .aluop     (aluop_i),
    .reg1      (reg1_i),
    .reg2      (reg2_i),
    .taken     (taken_s),
    .is_branch (is_branch_s)
  );

  assign do_branch_o = taken_s;
  assign resolve_s   = id_valid_i & ~flush_i & is_branch_s;
  assign miss_s      = resolve_s & (taken_s != id_pred_taken_i);

  // Saturating next value for the counter being resolved.
  always_comb begin
    cnt_cur_s = bht_r[update_idx_s];
    if (taken_s && (cnt_cur_s != CNT_MAX)) begin
      cnt_next_s = cnt_cur_s + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (!taken_s && (cnt_cur_s != CNT_MIN)) begin
      cnt_next_s = cnt_cur_s - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_next_s = cnt_cur_s;
    end
  end

  // Counter table; lookups read the registered array, so same-cycle updates are not visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_r[i] <= CNT_INIT;
      end
    end else if (resolve_s) begin
      bht_r[update_idx_s] <= cnt_next_s;
    end
  end

  // Registered lookup result and redirect pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_r  <= 1'b0;
      pred_taken_r  <= 1'b0;
      mispredict_r  <= 1'b0;
      redirect_pc_r <= {DATA_W{1'b0}};
    end else begin
      pred_valid_r <= if_valid_i & ~flush_i;
      pred_taken_r <= if_valid_i & ~flush_i & bht_r[lookup_idx_s][CNT_W-1];
      mispredict_r <= miss_s;
      if (miss_s) begin
        redirect_pc_r <= taken_s ? id_target_i : (id_pc_i + DELAY_SLOT_SKIP);
      end
    end
  end

  assign pred_valid_o  = pred_valid_r;
  assign pred_taken_o  = pred_taken_r;
  assign mispredict_o  = mispredict_r;
  assign redirect_pc_o = redirect_pc_r;

`ifdef BRANCH_PERF_EN
  logic [31:0] perf_branch_r;
  logic [31:0] perf_miss_r;

  // Free-running event counters, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branch_r <= 32'd0;
      perf_miss_r   <= 32'd0;
    end else begin
      perf_branch_r <= perf_branch_r + {31'd0, resolve_s};
      perf_miss_r   <= perf_miss_r + {31'd0, miss_s};
    end
  end

  assign perf_branch_o = perf_branch_r;
  assign perf_miss_o   = perf_miss_r;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios then random traffic
// checked against a behavioural predictor model (perf counters when BRANCH_PERF_EN is defined).
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  localparam int DEPTH = 256;
  localparam int CW    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i;
  logic [31:0] if_pc_i;
  logic        pred_valid_o;
  logic        pred_taken_o;
  logic        id_valid_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i, reg2_i, id_pc_i, id_target_i;
  logic        id_pred_taken_i;
  logic        flush_i;
  logic        do_branch_o;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
`ifdef BRANCH_PERF_EN
  logic [31:0] perf_branch_o, perf_miss_o;
  int unsigned m_perf_br, m_perf_miss;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_cnt [DEPTH];
  logic        m_pv, m_pt, m_mp;
  logic [31:0] m_rpc;

  always #5 clk = ~clk;

  branch_predict_unit #(.BHT_DEPTH(DEPTH), .CNT_W(CW), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i),
    .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
    .id_valid_i(id_valid_i), .aluop_i(aluop_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i),
    .id_pc_i(id_pc_i), .id_target_i(id_target_i),
    .id_pred_taken_i(id_pred_taken_i), .flush_i(flush_i),
    .do_branch_o(do_branch_o), .mispredict_o(mispredict_o),
    .redirect_pc_o(redirect_pc_o)
`ifdef BRANCH_PERF_EN
    , .perf_branch_o(perf_branch_o), .perf_miss_o(perf_miss_o)
`endif
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  // Branch semantics straight from the instruction definitions, with signed arithmetic.
  task automatic model_cond(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic taken, output logic is_br);
    is_br = 1'b1;
    if (op == EXE_BEQ_OP)                              taken = (a == b);
    else if (op == EXE_BNE_OP)                         taken = (a != b);
    else if (op == EXE_BGTZ_OP)                        taken = ($signed(a) > 0);
    else if (op == EXE_BLEZ_OP)                        taken = ($signed(a) <= 0);
    else if (op == EXE_BGEZ_OP || op == EXE_BGEZAL_OP) taken = ($signed(a) >= 0);
    else if (op == EXE_BLTZ_OP || op == EXE_BLTZAL_OP) taken = ($signed(a) < 0);
    else begin taken = 1'b0; is_br = 1'b0; end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_cnt[i] = 1;
    m_pv = 1'b0; m_pt = 1'b0; m_mp = 1'b0; m_rpc = 32'h0;
`ifdef BRANCH_PERF_EN
    m_perf_br = 0; m_perf_miss = 0;
`endif
  endtask

  // One clock: inputs are already applied (after a negedge). Checks combinational
  // outcome, advances the model, then checks registered outputs after the edge.
  task automatic step();
    logic tk, isb, resolve;
    #1;
    model_cond(aluop_i, reg1_i, reg2_i, tk, isb);
    check1("do_branch", do_branch_o, tk);
    if (rst) begin
      model_reset();
    end else begin
      m_pv = if_valid_i && !flush_i;
      m_pt = m_pv && (m_cnt[idx_of(if_pc_i)] >= 2);
      resolve = id_valid_i && !flush_i && isb;
      m_mp = resolve && (tk != id_pred_taken_i);
      if (m_mp) m_rpc = tk ? id_target_i : id_pc_i + 32'd8;
      if (resolve) begin
        if (tk && m_cnt[idx_of(id_pc_i)] < 3) m_cnt[idx_of(id_pc_i)]++;
        if (!tk && m_cnt[idx_of(id_pc_i)] > 0) m_cnt[idx_of(id_pc_i)]--;
      end
`ifdef BRANCH_PERF_EN
      if (resolve) m_perf_br++;
      if (m_mp) m_perf_miss++;
`endif
    end
    @(posedge clk);
    #1;
    check1("pred_valid", pred_valid_o, m_pv);
    check1("pred_taken", pred_taken_o, m_pt);
    check1("mispredict", mispredict_o, m_mp);
    check32("redirect_pc", redirect_pc_o, m_rpc);
`ifdef BRANCH_PERF_EN
    check32("perf_branch", perf_branch_o, m_perf_br);
    check32("perf_miss", perf_miss_o, m_perf_miss);
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; if_valid_i = 1'b0; if_pc_i = 32'h0; id_valid_i = 1'b0;
    aluop_i = 8'h00; reg1_i = 32'h0; reg2_i = 32'h0; id_pc_i = 32'h0;
    id_target_i = 32'h0; id_pred_taken_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic br(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
    idle();
    id_valid_i = 1'b1; aluop_i = op; reg1_i = a; reg2_i = b;
    id_pc_i = pc; id_target_i = tgt; id_pred_taken_i = pred;
  endtask

  task automatic lookup(input logic [31:0] pc);
    idle();
    if_valid_i = 1'b1; if_pc_i = pc;
  endtask

  logic [7:0] ops [8];

  initial begin
    ops = '{EXE_BEQ_OP, EXE_BNE_OP, EXE_BGTZ_OP, EXE_BLEZ_OP,
            EXE_BGEZ_OP, EXE_BGEZAL_OP, EXE_BLTZ_OP, EXE_BLTZAL_OP};
    model_reset();
    idle();
    @(negedge clk);
    rst = 1'b1; step();
    rst = 1'b1; step();

    // Lookup after reset: weakly not-taken
    lookup(32'h0040_0000); step();
    check1("reset_lookup_not_taken", pred_taken_o, 1'b0);

    // BEQ taken, predicted not-taken -> redirect to target
    br(EXE_BEQ_OP, 32'd5, 32'd5, 32'h100, 32'h200, 1'b0); step();
    check32("beq_redirect", redirect_pc_o, 32'h200);

    br(EXE_BLEZ_OP, 32'h8000_0000, 32'h0, 32'h104, 32'h500, 1'b1); step();
    br(EXE_BGTZ_OP, 32'h0, 32'h0, 32'h108, 32'h600, 1'b0); step();
    br(EXE_BNE_OP, 32'd1, 32'd1, 32'h300, 32'h700, 1'b1); step();
    check32("bne_fallthrough", redirect_pc_o, 32'h308);

    // Back-to-back mispredicts then redirect hold
    br(EXE_BLTZ_OP, 32'hFFFF_FFFF, 32'h0, 32'h400, 32'h440, 1'b0); step();
    br(EXE_BGEZ_OP, 32'hFFFF_FFFF, 32'h0, 32'h500, 32'h540, 1'b1); step();
    idle(); step();

    // Saturation at 0x40
    for (int i = 0; i < 3; i++) begin br(EXE_BEQ_OP, 32'd1, 32'd1, 32'h40, 32'h80, 1'b1); step(); end
    lookup(32'h40); step();
    check1("sat_lookup_taken", pred_taken_o, 1'b1);
    for (int i = 0; i < 2; i++) begin br(EXE_BEQ_OP, 32'd1, 32'd2, 32'h40, 32'h80, 1'b0); step(); end
    lookup(32'h40); step();
    check1("dec_lookup_not_taken", pred_taken_o, 1'b0);

    // Same-cycle lookup and update at 0x80
    br(EXE_BEQ_OP, 32'd3, 32'd3, 32'h80, 32'hC0, 1'b1);
    if_valid_i = 1'b1; if_pc_i = 32'h80; step();
    check1("same_cycle_old_value", pred_taken_o, 1'b0);
    lookup(32'h80); step();
    check1("after_update_taken", pred_taken_o, 1'b1);

    // Flush suppresses the mispredict, the lookup and the update
    br(EXE_BEQ_OP, 32'd9, 32'd9, 32'h40, 32'h99C, 1'b0);
    flush_i = 1'b1; if_valid_i = 1'b1; if_pc_i = 32'h80; step();
    check1("flush_no_mispredict", mispredict_o, 1'b0);
    lookup(32'h40); step();
    check1("flush_counter_unchanged", pred_taken_o, 1'b0);

    // Reset concurrent with a mispredicting resolution
    br(EXE_BEQ_OP, 32'd9, 32'd9, 32'h40, 32'h99C, 1'b0);
    rst = 1'b1; step();
    check1("rst_drops_mispredict", mispredict_o, 1'b0);
    check32("rst_clears_redirect", redirect_pc_o, 32'h0);
`ifdef BRANCH_PERF_EN
    check32("perf_branch_rst", perf_branch_o, 32'h0);
`endif

    // Randomized traffic over a handful of indices
    for (int n = 0; n < 600; n++) begin
      idle();
      rst             = ($urandom_range(0, 79) == 0);
      flush_i         = ($urandom_range(0, 9) == 0);
      if_valid_i      = 1'($urandom_range(0, 1));
      if_pc_i         = 32'h1000 + ($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      id_valid_i      = ($urandom_range(0, 3) != 0);
      aluop_i         = ($urandom_range(0, 5) == 0) ? 8'($urandom) : ops[$urandom_range(0, 7)];
      reg2_i          = $urandom;
      case ($urandom_range(0, 3))
        0:       reg1_i = 32'h0;
        1:       reg1_i = reg2_i;
        2:       reg1_i = 32'h8000_0000 | $urandom;
        default: reg1_i = $urandom;
      endcase
      id_pc_i         = 32'h1000 + ($urandom_range(0, 7) << 2);
      id_target_i     = $urandom & 32'hFFFF_FFFC;
      id_pred_taken_i = 1'($urandom_range(0, 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter BHT_DEPTH, default 256, number of 2-bit counters; SHALL be a power of two, 16..1024.
REQ-002 Parameter CNT_W, default 2, saturating counter width, 2..3.
REQ-003 Parameter DATA_W, default 32, operand and PC width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 if_valid_i  in  1  fetch lookup request.
REQ-007 if_pc_i  in  DATA_W  fetch PC for lookup.
REQ-008 pred_valid_o  out  1  registered lookup result valid.
REQ-009 pred_taken_o  out  1  registered prediction; taken when counter MSB=1.
REQ-010 id_valid_i  in  1  instruction in ID is valid and not stalled.
REQ-011 aluop_i  in  8  ALU op code, branch codes from shared defines.
REQ-012 reg1_i, reg2_i  in  DATA_W each  source operands.
REQ-013 id_pc_i  in  DATA_W  branch PC.
REQ-014 id_target_i  in  DATA_W  computed branch target.
REQ-015 id_pred_taken_i  in  1  prediction carried down with the instruction.
REQ-016 flush_i  in  1  exception/ERET flush.
REQ-017 do_branch_o  out  1  combinational actual branch outcome.
REQ-018 mispredict_o  out  1  registered one-cycle redirect pulse.
REQ-019 redirect_pc_o  out  DATA_W  registered correct next fetch PC.

Function
REQ-020 Index SHALL be pc[log2(BHT_DEPTH)+1:2] for both lookup and update.
REQ-021 Lookup latency SHALL be 1 cycle: pred_valid_o = registered if_valid_i; pred_taken_o = MSB of indexed counter, 0 when not valid.
REQ-022 Branch condition, for DATA_W-bit operands: BEQ reg1==reg2; BNE reg1!=reg2; BGTZ sign=0 and nonzero; BLEZ sign=1 or zero; BGEZ/BGEZAL sign=0; BLTZ/BLTZAL sign=1; any other aluop_i -> do_branch_o=0.
REQ-023 A resolution SHALL occur when id_valid_i=1, flush_i=0 and aluop_i is a conditional branch code.
REQ-024 On resolution the indexed counter SHALL increment if taken and decrement if not, saturating at 0 and 2^CNT_W-1.
REQ-025 Lookup and update to the same index in one cycle: lookup SHALL return the pre-update value.
REQ-026 On resolution with do_branch_o != id_pred_taken_i: next cycle mispredict_o=1; redirect_pc_o = id_target_i if taken, else id_pc_i+8 (past delay slot).
REQ-027 mispredict_o SHALL be high for exactly one cycle per mispredicting resolution; back-to-back resolutions yield back-to-back pulses.
REQ-028 flush_i=1 SHALL suppress counter update, force mispredict_o=0 next cycle and force pred_valid_o=0 next cycle.
REQ-029 redirect_pc_o SHALL hold its last value when mispredict_o=0.

Reset
REQ-030 rst SHALL set every counter to weakly not-taken (2^(CNT_W-1)-1).
REQ-031 rst SHALL clear pred_valid_o, pred_taken_o, mispredict_o, redirect_pc_o (0).
REQ-032 rst SHALL take priority over any concurrent lookup, resolution or flush; a pending mispredict is dropped.

Configuration
REQ-033 Macro BRANCH_PERF_EN: when defined, adds outputs perf_branch_o and perf_miss_o (32 bits each), counting resolutions and mispredicts, wrapping at 2^32, cleared by rst.
REQ-034 Without BRANCH_PERF_EN those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-035 Branch aluop codes and counter reset constant SHALL live in the shared defines package; the enum of branch kinds is a package typedef.
REQ-036 Condition evaluation SHALL be a combinational sub-module branch_cond_eval (aluop, reg1, reg2 -> taken, is_branch).

Verification
REQ-037 After reset, lookup pc=0x00400000 -> next cycle pred_valid_o=1, pred_taken_o=0.
REQ-038 BEQ reg1=reg2=5, pred=0, pc=0x100, target=0x200 -> do_branch_o=1; next cycle mispredict_o=1, redirect_pc_o=0x200.
REQ-039 BLEZ reg1=0x80000000, then BGTZ reg1=0: first taken, second not taken; BNE reg1=1 reg2=1, pred=1, pc=0x300 -> redirect_pc_o=0x308.
REQ-040 Three taken resolutions at pc=0x40 -> counter saturates at 3; lookup 0x40 -> taken; two not-taken -> counter 1, lookup not taken.
REQ-041 Same-cycle lookup and update at pc=0x80 from counter 1 -> lookup returns 0; following lookup returns 1.
REQ-042 Mispredicting resolution with flush_i=1, then rst during a pending pulse -> no mispredict_o, counter unchanged; perf counters (BRANCH_PERF_EN) read 0 after rst.
